// File: rtl/jednostka_skoku_pkg.sv
// Shared definitions for the branch unit: jump-type codes, flag bit
// positions inside the {N,C,V,Z} flag word and the RUN/FLUSH state type.
package jednostka_skoku_pkg;

  localparam logic [3:0] SK_NONE = 4'd0;
  localparam logic [3:0] SK_JMP  = 4'd1;
  localparam logic [3:0] SK_JZ   = 4'd2;
  localparam logic [3:0] SK_JNZ  = 4'd3;
  localparam logic [3:0] SK_JC   = 4'd4;
  localparam logic [3:0] SK_JNC  = 4'd5;
  localparam logic [3:0] SK_JN   = 4'd6;
  localparam logic [3:0] SK_JNN  = 4'd7;
  localparam logic [3:0] SK_JV   = 4'd8;
  localparam logic [3:0] SK_JNV  = 4'd9;
  localparam logic [3:0] SK_CALL = 4'd10;
  localparam logic [3:0] SK_RET  = 4'd11;

  // flag word layout is {N,C,V,Z}
  localparam int FL_Z = 0;
  localparam int FL_V = 1;
  localparam int FL_C = 2;
  localparam int FL_N = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } stan_e;

endpackage

// File: rtl/jednostka_skoku_if.sv
// Bus between decoder/ALU and the branch unit.
//   master: drives en, rodzaj_skoku, cel, flagi_alu, flagi_we;
//           receives pc, skok, flush, stos_blad
//   slave : the branch unit side
interface jednostka_skoku_if #(
  parameter int ADDR_W = 8
);
  logic              en;
  logic [3:0]        rodzaj_skoku;
  logic [ADDR_W-1:0] cel;
  logic [3:0]        flagi_alu;
  logic              flagi_we;
  logic [ADDR_W-1:0] pc;
  logic              skok;
  logic              flush;
  logic              stos_blad;

  modport master (
    output en, rodzaj_skoku, cel, flagi_alu, flagi_we,
    input  pc, skok, flush, stos_blad
  );

  modport slave (
    input  en, rodzaj_skoku, cel, flagi_alu, flagi_we,
    output pc, skok, flush, stos_blad
  );
endinterface

// File: rtl/jednostka_skoku_stos_powrotu.sv
// Return-address stack (LIFO).
//   clk, rst : clock, async active-high reset
//   push/din : push din when not full (ignored when full)
//   pop      : drop top entry when not empty
//   top      : current top entry (0 when empty)
//   pelny    : full, pusty : empty
// The caller never asserts push and pop together.
module stos_powrotu #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              pelny,
  output logic              pusty
);
  localparam int SP_W = $clog2(RAS_DEPTH + 1);

  logic [SP_W-1:0]                   sp_q, sp_d;
  logic [RAS_DEPTH-1:0][ADDR_W-1:0]  mem_q, mem_d;

  assign pusty = (sp_q == '0);
  assign pelny = (sp_q == SP_W'(RAS_DEPTH));

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    top   = '0;
    // sp points one past the top entry
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = mem_q[i];
    end
    if (push && !pelny) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (sp_q == SP_W'(i)) mem_d[i] = din;
      end
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !pusty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      mem_q <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/jednostka_skoku.sv
// Branch unit: owns PC, the registered ALU flags and a return-address stack.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of jednostka_skoku_if
//              (en, rodzaj_skoku, cel, flagi_alu, flagi_we in;
//               pc, skok, flush, stos_blad out)
// A taken jump raises flush for FLUSH_CYCLES cycles starting on the next
// edge; during that window the pc holds and decode requests are ignored.
module jednostka_skoku
  import jednostka_skoku_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  jednostka_skoku_if.slave  bus
);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] JEDEN = ADDR_W'(1);

  stan_e             state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flagi_q, flagi_d;
  logic              flush_q, flush_d;
  logic              blad_q, blad_d;

  logic              skok, wydaj, is_call, is_ret, push, pop;
  logic [ADDR_W-1:0] top;
  logic              pelny, pusty;

  // RET's stack check is applied outside; here it counts as "true".
  function automatic logic warunek(input logic [3:0] kod, input logic [3:0] fl);
    case (kod)
      SK_JMP, SK_CALL, SK_RET: warunek = 1'b1;
      SK_JZ:  warunek =  fl[FL_Z];
      SK_JNZ: warunek = !fl[FL_Z];
      SK_JC:  warunek =  fl[FL_C];
      SK_JNC: warunek = !fl[FL_C];
      SK_JN:  warunek =  fl[FL_N];
      SK_JNN: warunek = !fl[FL_N];
      SK_JV:  warunek =  fl[FL_V];
      SK_JNV: warunek = !fl[FL_V];
      default: warunek = 1'b0;
    endcase
  endfunction

  stos_powrotu #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_stos (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + JEDEN),
    .top   (top),
    .pelny (pelny),
    .pusty (pusty)
  );

  always_comb begin
    // the next flag value doubles as the bypassed evaluation source
    flagi_d = bus.flagi_we ? bus.flagi_alu : flagi_q;
    wydaj   = bus.en && (state_q == ST_RUN);
    is_call = (bus.rodzaj_skoku == SK_CALL);
    is_ret  = (bus.rodzaj_skoku == SK_RET);
    skok    = wydaj && warunek(bus.rodzaj_skoku, flagi_d) && !(is_ret && pusty);
    // CALL is always taken; a full stack just drops the push
    push    = wydaj && is_call;
    pop     = skok && is_ret;
    blad_d  = blad_q || (push && pelny) || (wydaj && is_ret && pusty);

    pc_d = pc_q;
    if (wydaj) pc_d = skok ? (is_ret ? top : bus.cel) : pc_q + JEDEN;

    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (skok && FLUSH_CYCLES > 0) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
      flagi_q <= '0;
      flush_q <= 1'b0;
      blad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flagi_q <= flagi_d;
      flush_q <= flush_d;
      blad_q  <= blad_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.skok      = skok;
  assign bus.flush     = flush_q;
  assign bus.stos_blad = blad_q;
endmodule

// File: tb/tb_jednostka_skoku.sv
// Self-checking bench for jednostka_skoku (ADDR_W=8, RAS_DEPTH=2,
// FLUSH_CYCLES=2). Reference model: pc byte, flag nibble, queue as the
// return stack and a count of remaining bubble cycles.
module tb_jednostka_skoku;
  localparam int AW = 8;
  localparam int RD = 2;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jednostka_skoku_if #(.ADDR_W(AW)) bus ();
  jednostka_skoku #(.ADDR_W(AW), .RAS_DEPTH(RD), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_ok  = 0;

  logic [7:0] m_pc;
  logic [3:0] m_fl;
  logic [7:0] m_stk[$];
  int         m_left;
  logic       m_err;
  logic       exp_skok;

  // f = {N,C,V,Z}
  function automatic logic m_cond(input logic [3:0] k, input logic [3:0] f, input int depth);
    case (k)
      4'd1, 4'd10: return 1'b1;
      4'd2: return f[0];
      4'd3: return !f[0];
      4'd4: return f[2];
      4'd5: return !f[2];
      4'd6: return f[3];
      4'd7: return !f[3];
      4'd8: return f[1];
      4'd9: return !f[1];
      4'd11: return depth > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_pc = 8'h00; m_fl = 4'h0; m_stk.delete(); m_left = 0; m_err = 1'b0;
  endtask

  // called just after a falling edge
  task automatic apply(input logic e, input logic [3:0] k, input logic [7:0] c,
                       input logic [3:0] fa, input logic fwe);
    bus.en = e; bus.rodzaj_skoku = k; bus.cel = c; bus.flagi_alu = fa; bus.flagi_we = fwe;
    exp_skok = e && (m_left == 0) && m_cond(k, fwe ? fa : m_fl, m_stk.size());
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_left > 0) m_left--;
    else if (bus.en) begin
      if (exp_skok) begin
        if (bus.rodzaj_skoku == 4'd10) begin
          if (m_stk.size() < RD) m_stk.push_back(m_pc + 8'd1);
          else m_err = 1'b1;
          m_pc = bus.cel;
        end else if (bus.rodzaj_skoku == 4'd11) m_pc = m_stk.pop_back();
        else m_pc = bus.cel;
        m_left = FC;
      end else begin
        if (bus.rodzaj_skoku == 4'd11) m_err = 1'b1;
        m_pc = m_pc + 8'd1;
      end
    end
    if (bus.flagi_we) m_fl = bus.flagi_alu;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && m_left > 0; i++) begin
      apply(0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    apply(1, 4'd1, 8'h37, 0, 0);
    tick();
    n_chk++; if (bus.pc !== 8'h37 || bus.flush !== 1'b1)
      $display("FAIL rst_pre pc=%h flush=%b need 37/1", bus.pc, bus.flush); else n_ok++;
    apply(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    m_reset();
    n_chk++; if ({bus.pc, bus.flush, bus.stos_blad, bus.skok} !== 11'd0)
      $display("FAIL rst_async pc=%h flush=%b blad=%b skok=%b need all 0",
               bus.pc, bus.flush, bus.stos_blad, bus.skok); else n_ok++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1, 4'd0, 8'h99, 0, 0);
      tick();
    end
    n_chk++; if (bus.pc !== 8'h03 || bus.flush !== 1'b0)
      $display("FAIL rst_after pc=%h flush=%b need 03/0", bus.pc, bus.flush); else n_ok++;
  endtask

  task automatic test_bypass_flush();
    apply(1, 4'd2, 8'h40, 4'b0001, 1);
    n_chk++; if (bus.skok !== 1'b1 || exp_skok !== 1'b1)
      $display("FAIL byp_skok got %b need 1", bus.skok); else n_ok++;
    tick();
    n_chk++; if (bus.pc !== 8'h40 || bus.flush !== 1'b1)
      $display("FAIL byp_pc pc=%h flush=%b need 40/1", bus.pc, bus.flush); else n_ok++;
    for (int i = 0; i < 2; i++) begin
      apply(1, 4'd1, 8'h99, 0, 0);
      n_chk++; if (bus.skok !== 1'b0)
        $display("FAIL flush_skok[%0d] got %b need 0", i, bus.skok); else n_ok++;
      tick();
      n_chk++; if (bus.pc !== 8'h40 || bus.flush !== (i == 0))
        $display("FAIL flush_hold[%0d] pc=%h flush=%b need 40/%b", i, bus.pc, bus.flush, i == 0);
      else n_ok++;
    end
  endtask

  task automatic test_conditions();
    logic [3:0] pos_code[4] = '{4'd2, 4'd4, 4'd6, 4'd8};
    int         bitpos[4]   = '{0, 2, 3, 1};
    logic [7:0] c;
    for (int b = 0; b < 4; b++) begin
      apply(0, 0, 0, 4'b0000, 1);
      tick();
      for (int v = 0; v < 3; v++) begin
        c = 8'($urandom_range(0, 255));
        case (v)
          0: apply(1, pos_code[b], c, 0, 0);
          1: apply(1, pos_code[b] + 4'd1, c, 0, 0);
          default: apply(1, pos_code[b], c, 4'(1 << bitpos[b]), 1);
        endcase
        n_chk++; if (bus.skok !== exp_skok || exp_skok !== (v != 0))
          $display("FAIL cond[%0d,%0d] skok=%b need %b", b, v, bus.skok, exp_skok); else n_ok++;
        tick();
        n_chk++; if (bus.pc !== m_pc)
          $display("FAIL cond_pc[%0d,%0d] pc=%h need %h", b, v, bus.pc, m_pc); else n_ok++;
        drain();
      end
    end
  endtask

  task automatic test_wrap();
    apply(1, 4'd1, 8'hFF, 0, 0); tick(); drain();
    apply(1, 4'd0, 8'h55, 0, 0); tick();
    n_chk++; if (bus.pc !== 8'h00)
      $display("FAIL wrap_pc pc=%h need 00", bus.pc); else n_ok++;
    apply(1, 4'd1, 8'hFF, 0, 0); tick(); drain();
    apply(1, 4'd10, 8'h10, 0, 0); tick();
    n_chk++; if (bus.pc !== 8'h10)
      $display("FAIL wrap_call pc=%h need 10", bus.pc); else n_ok++;
    drain();
    apply(1, 4'd11, 8'h77, 0, 0);
    n_chk++; if (bus.skok !== 1'b1)
      $display("FAIL wrap_ret_skok got %b need 1", bus.skok); else n_ok++;
    tick();
    n_chk++; if (bus.pc !== 8'h00 || bus.pc !== m_pc)
      $display("FAIL wrap_ret pc=%h need 00", bus.pc); else n_ok++;
    drain();
  endtask

  task automatic test_nested_calls();
    apply(1, 4'd1, 8'h05, 0, 0); tick(); drain();
    apply(1, 4'd10, 8'h20, 0, 0); tick(); drain();
    apply(1, 4'd10, 8'h30, 0, 0); tick(); drain();
    n_chk++; if (bus.stos_blad !== 1'b0 || bus.pc !== 8'h30)
      $display("FAIL call2 blad=%b pc=%h need 0/30", bus.stos_blad, bus.pc); else n_ok++;
    apply(1, 4'd10, 8'h50, 0, 0);
    n_chk++; if (bus.skok !== 1'b1)
      $display("FAIL call3_skok got %b need 1", bus.skok); else n_ok++;
    tick();
    n_chk++; if (bus.stos_blad !== 1'b1 || bus.pc !== 8'h50)
      $display("FAIL call3 blad=%b pc=%h need 1/50", bus.stos_blad, bus.pc); else n_ok++;
    drain();
    apply(1, 4'd11, 0, 0, 0); tick();
    n_chk++; if (bus.pc !== 8'h21)
      $display("FAIL ret1 pc=%h need 21", bus.pc); else n_ok++;
    drain();
    apply(1, 4'd11, 0, 0, 0); tick();
    n_chk++; if (bus.pc !== 8'h06)
      $display("FAIL ret2 pc=%h need 06", bus.pc); else n_ok++;
    drain();
  endtask

  task automatic test_ret_empty();
    apply(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    apply(1, 4'd1, 8'h08, 0, 0); tick(); drain();
    apply(1, 4'd11, 8'h44, 0, 0);
    n_chk++; if (bus.skok !== 1'b0)
      $display("FAIL ret_empty_skok got %b need 0", bus.skok); else n_ok++;
    tick();
    n_chk++; if (bus.pc !== 8'h09 || bus.stos_blad !== 1'b1 || bus.flush !== 1'b0)
      $display("FAIL ret_empty pc=%h blad=%b flush=%b need 09/1/0", bus.pc, bus.stos_blad, bus.flush);
    else n_ok++;
    apply(1, 4'd13, 8'h77, 4'hF, 1);
    n_chk++; if (bus.skok !== 1'b0)
      $display("FAIL code13_skok got %b need 0", bus.skok); else n_ok++;
    tick();
    n_chk++; if (bus.pc !== 8'h0A || bus.stos_blad !== 1'b1)
      $display("FAIL code13 pc=%h blad=%b need 0A/1", bus.pc, bus.stos_blad); else n_ok++;
  endtask

  task automatic test_random();
    logic [3:0] k;
    apply(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 400; i++) begin
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 11)) : 4'($urandom_range(0, 15));
      apply($urandom_range(0, 3) != 0, k, 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_chk++; if (bus.skok !== exp_skok)
        $display("FAIL rnd_skok[%0d] got %b need %b", i, bus.skok, exp_skok); else n_ok++;
      tick();
      n_chk++; if (bus.pc !== m_pc || bus.flush !== (m_left > 0) || bus.stos_blad !== m_err)
        $display("FAIL rnd_state[%0d] pc=%h flush=%b blad=%b need %h/%b/%b",
                 i, bus.pc, bus.flush, bus.stos_blad, m_pc, m_left > 0, m_err);
      else n_ok++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 0; bus.rodzaj_skoku = 0; bus.cel = 0; bus.flagi_alu = 0; bus.flagi_we = 0;
    m_reset();
    @(negedge clk);
    #1;
    n_chk++; if ({bus.pc, bus.flush, bus.stos_blad, bus.skok} !== 11'd0)
      $display("FAIL por pc=%h flush=%b blad=%b skok=%b need all 0",
               bus.pc, bus.flush, bus.stos_blad, bus.skok); else n_ok++;
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_bypass_flush();
    test_conditions();
    test_wrap();
    test_nested_calls();
    test_ret_empty();
    test_random();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
